// File: rtl/exec_mul_ctrl.sv
// Purpose : iterative shift-add multiplier controller for the execute stage.
// Latency : 1 accept cycle + (msb index of multiplier + 2) RUN cycles, then 1 DONE cycle.
// Backpressure: stall_E holds upstream while accepting/running; flush_E aborts a run.
//
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   mulReq_E, flush_E   - MUL present in execute / execute instruction squashed
//   readData1_E/2_E     - multiplicand / multiplier operands (N bits)
//   aluResult_E         - shared ALU result, passed through when no product is ready
//   result_E            - execute result to memory stage
//   stall_E             - pipeline hold request
//   mulDone_E           - one-cycle pulse when result_E carries the product
//   mulCycles           - RUN cycles used by the last completed multiply
module exec_mul_ctrl #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mulReq_E,
  input  logic         flush_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  input  logic [N-1:0] aluResult_E,
  output logic [N-1:0] result_E,
  output logic         stall_E,
  output logic         mulDone_E,
  output logic [6:0]   mulCycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] mcand, mcand_nxt;
  logic [N-1:0] mplr, mplr_nxt;
  logic [N-1:0] prod, prod_nxt;
  logic [6:0]   cnt, cnt_nxt;
  logic [6:0]   cycles_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplr      <= '0;
      prod      <= '0;
      cnt       <= '0;
      mulCycles <= '0;
    end else begin
      state     <= state_nxt;
      mcand     <= mcand_nxt;
      mplr      <= mplr_nxt;
      prod      <= prod_nxt;
      cnt       <= cnt_nxt;
      mulCycles <= cycles_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mcand_nxt  = mcand;
    mplr_nxt   = mplr;
    prod_nxt   = prod;
    cnt_nxt    = cnt;
    cycles_nxt = mulCycles;
    stall_E    = 1'b0;
    mulDone_E  = 1'b0;
    result_E   = aluResult_E;

    case (state)
      IDLE: begin
        if (mulReq_E && !flush_E) begin
          stall_E   = 1'b1;
          mcand_nxt = readData1_E;
          mplr_nxt  = readData2_E;
          prod_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (flush_E) begin
          // Squashed instruction: release the pipeline now, drop the partial product.
          state_nxt = IDLE;
        end else begin
          stall_E = 1'b1;
          cnt_nxt = cnt + 7'd1;
          if (mplr != '0) begin
            if (mplr[0]) begin
              prod_nxt = prod + mcand;
            end
            // Bits shifted out of the top are dropped: product is kept mod 2^N.
            mcand_nxt = mcand << 1;
            mplr_nxt  = mplr >> 1;
          end else begin
            // Multiplier exhausted; this final cycle is still counted.
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        // mulReq_E is still high for this same MUL, so never restart from here.
        mulDone_E  = 1'b1;
        result_E   = prod;
        cycles_nxt = cnt;
        state_nxt  = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_exec_mul_ctrl.sv
module tb_exec_mul_ctrl;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         mulReq_E;
  logic         flush_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic [N-1:0] aluResult_E;
  logic [N-1:0] result_E;
  logic         stall_E;
  logic         mulDone_E;
  logic [6:0]   mulCycles;

  int n_cmp  = 0;
  int n_fail = 0;
  int last_cycles = 0;

  exec_mul_ctrl #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .mulReq_E    (mulReq_E),
    .flush_E     (flush_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .aluResult_E (aluResult_E),
    .result_E    (result_E),
    .stall_E     (stall_E),
    .mulDone_E   (mulDone_E),
    .mulCycles   (mulCycles)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // RUN cycles: one per multiplier bit up to the highest set bit, plus one final cycle.
  function automatic int ref_cycles(input logic [N-1:0] b);
    int hb;
    if (b == '0) return 1;
    hb = 0;
    for (int i = 0; i < N; i++) if (b[i]) hb = i;
    return hb + 2;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply from IDLE. hold keeps mulReq_E high into the following IDLE
  // cycle (back-to-back); fl_done asserts flush_E during the DONE cycle.
  task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit hold, input bit fl_done);
    logic [N-1:0] exp_p;
    int exp_c;
    int n;
    exp_p = a * b;
    exp_c = ref_cycles(b);
    aluResult_E = rnd64();
    readData1_E = a;
    readData2_E = b;
    mulReq_E    = 1'b1;
    flush_E     = 1'b0;
    #1;
    chk("accept_stall", N'(stall_E), N'(1));
    n = 0;
    while (stall_E === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("stall_len", N'(n), N'(exp_c + 1));
    if (fl_done) begin
      flush_E = 1'b1;
      #1;
    end
    chk("done_pulse", N'(mulDone_E), N'(1));
    chk("done_result", result_E, exp_p);
    chk("done_stall", N'(stall_E), N'(0));
    if (!hold) mulReq_E = 1'b0;
    flush_E     = 1'b0;
    aluResult_E = rnd64();
    step();
    chk("mul_cycles", N'(mulCycles), N'(exp_c));
    chk("idle_no_pulse", N'(mulDone_E), N'(0));
    chk("idle_result", result_E, aluResult_E);
    if (!hold) chk("idle_stall", N'(stall_E), N'(0));
    last_cycles = exp_c;
  endtask

  initial begin
    reset       = 1'b0;
    mulReq_E    = 1'b0;
    flush_E     = 1'b0;
    readData1_E = '0;
    readData2_E = '0;
    aluResult_E = 64'hDEAD_BEEF_0000_1111;
    #2;
    chk("rst_stall", N'(stall_E), N'(0));
    chk("rst_result", result_E, 64'hDEAD_BEEF_0000_1111);
    chk("rst_pulse", N'(mulDone_E), N'(0));
    chk("rst_cycles", N'(mulCycles), N'(0));
    mulReq_E = 1'b1;
    #1;
    chk("rst_stall_req", N'(stall_E), N'(1));
    mulReq_E = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();

    // Directed cases.
    do_mul(64'd7, 64'd5, 1'b0, 1'b0);
    do_mul(64'h1234, 64'd0, 1'b0, 1'b0);
    do_mul('1, '1, 1'b0, 1'b0);
    do_mul(64'd2, 64'd3, 1'b1, 1'b0);
    do_mul(64'd4, 64'd5, 1'b0, 1'b0);
    do_mul(64'd9, 64'd11, 1'b0, 1'b1);

    // Flush in the second RUN cycle.
    readData1_E = 64'd3;
    readData2_E = 64'h8;
    mulReq_E    = 1'b1;
    step();
    chk("fl_run1_stall", N'(stall_E), N'(1));
    step();
    flush_E     = 1'b1;
    aluResult_E = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("fl_stall", N'(stall_E), N'(0));
    chk("fl_result", result_E, 64'h0123_4567_89AB_CDEF);
    chk("fl_pulse", N'(mulDone_E), N'(0));
    step();
    flush_E  = 1'b0;
    mulReq_E = 1'b0;
    #1;
    chk("fl_idle_stall", N'(stall_E), N'(0));
    for (int i = 0; i < 6; i++) begin
      chk("fl_no_pulse", N'(mulDone_E), N'(0));
      step();
    end
    chk("fl_cycles_kept", N'(mulCycles), N'(last_cycles));

    // Asynchronous reset mid-RUN.
    readData1_E = 64'd77;
    readData2_E = 64'hFF;
    mulReq_E    = 1'b1;
    step();
    step();
    step();
    #1;
    reset    = 1'b0;
    mulReq_E = 1'b0;
    #1;
    chk("arst_stall", N'(stall_E), N'(0));
    chk("arst_cycles", N'(mulCycles), N'(0));
    chk("arst_pulse", N'(mulDone_E), N'(0));
    chk("arst_result", result_E, aluResult_E);
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("arst_quiet_pulse", N'(mulDone_E), N'(0));
      chk("arst_quiet_stall", N'(stall_E), N'(0));
      step();
    end

    // Randomized multiplies against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] ra, rb;
      ra = rnd64();
      rb = rnd64() >> $urandom_range(0, 64);
      do_mul(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
